// File: rtl/peripherals_pkg.sv
// Shared types for the peripheral manager: button bundle, view modes and
// the decoded button action used by the register view controller.
package peripherals;

  // Raw or conditioned button set, one bit per physical button.
  typedef struct packed {
    logic center;
    logic up;
    logic down;
    logic left;
    logic right;
  } buttons_t;

  localparam int NUM_BUTTONS = $bits(buttons_t);

  // What the register view is currently showing.
  typedef enum logic [1:0] {
    VIEW_MANUAL = 2'd0,
    VIEW_AUTO   = 2'd1,
    VIEW_FROZEN = 2'd2
  } view_mode_t;

  // Single winning button press for a cycle.
  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_CENTER = 3'd1,
    ACT_UP     = 3'd2,
    ACT_DOWN   = 3'd3,
    ACT_LEFT   = 3'd4,
    ACT_RIGHT  = 3'd5
  } action_t;

  // Collapse simultaneous press pulses: center > up > down > left > right.
  function automatic action_t decode_action(input buttons_t pulses);
    action_t act;
    act = ACT_NONE;
    if (pulses.center)     act = ACT_CENTER;
    else if (pulses.up)    act = ACT_UP;
    else if (pulses.down)  act = ACT_DOWN;
    else if (pulses.left)  act = ACT_LEFT;
    else if (pulses.right) act = ACT_RIGHT;
    return act;
  endfunction

endpackage

// File: rtl/register_view_controller_debouncer.sv
// Conditions one raw button pin: two-flop synchroniser, stability counter
// and a one-cycle pulse on each accepted rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock_100mhz,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync_meta;
  logic sync_out;
  logic [CNT_W-1:0] count;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      stable  <= 1'b0;
      count   <= '0;
      pressed <= 1'b0;
    end else begin
      pressed <= 1'b0;
      if (sync_out != stable) begin
        if (count == CNT_LAST) begin
          stable  <= sync_out;
          count   <= '0;
          pressed <= sync_out;
        end else begin
          count <= count + CNT_W'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/register_view_controller.sv
// Debug view selector: picks one CPU state word for the seven-segment
// display, with manual stepping, timed auto-scan and a frozen snapshot.
module register_view_controller
  import peripherals::*;
#(
  parameter int NUM_WORDS       = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DWELL_CYCLES    = 100_000_000,
  parameter int FLASH_CYCLES    = 25_000_000
) (
  input  logic                            clock_100mhz,
  input  logic                            reset,
  input  buttons_t                        buttons,
  input  logic [NUM_WORDS-1:0][31:0]      words,
  output logic [$clog2(NUM_WORDS)-1:0]    selected_idx,
  output logic [31:0]                     displayed_word,
  output view_mode_t                      mode,
  output logic                            flash
);

  localparam int IDX_W   = $clog2(NUM_WORDS);
  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
  localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_WORDS - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES);

  logic [NUM_BUTTONS-1:0] raw_vec;
  logic [NUM_BUTTONS-1:0] pressed_vec;
  logic [NUM_BUTTONS-1:0] unused_stable;
  action_t                action;

  view_mode_t         next_mode;
  logic [IDX_W-1:0]   next_idx;
  logic [DWELL_W-1:0] dwell_count;
  logic [DWELL_W-1:0] next_dwell;
  logic [FLASH_W-1:0] flash_count;
  logic [31:0]        snapshot;
  logic               load_snapshot;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] i);
    return (i == '0) ? LAST_IDX : i - IDX_W'(1);
  endfunction

  assign raw_vec = buttons;

  for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_debounce
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock_100mhz(clock_100mhz),
      .reset       (reset),
      .raw         (raw_vec[b]),
      .stable      (unused_stable[b]),
      .pressed     (pressed_vec[b])
    );
  end

  assign action = decode_action(buttons_t'(pressed_vec));
  assign flash  = (flash_count != '0);

  // Mode transitions, index stepping and dwell timing; a button always beats dwell expiry.
  always_comb begin
    next_mode     = mode;
    next_idx      = selected_idx;
    next_dwell    = '0;
    load_snapshot = 1'b0;
    case (mode)
      VIEW_MANUAL: begin
        case (action)
          ACT_UP:     next_idx = idx_inc(selected_idx);
          ACT_DOWN:   next_idx = idx_dec(selected_idx);
          ACT_RIGHT:  next_mode = VIEW_AUTO;
          ACT_LEFT: begin
            next_mode     = VIEW_FROZEN;
            load_snapshot = 1'b1;
          end
          ACT_CENTER: next_idx = '0;
          default:    next_idx = selected_idx;
        endcase
      end
      VIEW_AUTO: begin
        case (action)
          ACT_UP:     next_idx = idx_inc(selected_idx);
          ACT_DOWN:   next_idx = idx_dec(selected_idx);
          ACT_RIGHT:  next_mode = VIEW_MANUAL;
          ACT_LEFT: begin
            next_mode     = VIEW_FROZEN;
            load_snapshot = 1'b1;
          end
          ACT_CENTER: next_idx = '0;
          default: begin
            if (dwell_count == DWELL_LAST) begin
              next_idx = idx_inc(selected_idx);
            end else begin
              next_dwell = dwell_count + DWELL_W'(1);
            end
          end
        endcase
      end
      VIEW_FROZEN: begin
        case (action)
          ACT_LEFT:   next_mode = VIEW_MANUAL;
          ACT_CENTER: begin
            next_idx  = '0;
            next_mode = VIEW_MANUAL;
          end
          default:    next_mode = VIEW_FROZEN;
        endcase
      end
      default: next_mode = VIEW_MANUAL;
    endcase
  end

  // Mode, index, dwell counter and snapshot registers.
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      mode         <= VIEW_MANUAL;
      selected_idx <= '0;
      dwell_count  <= '0;
      snapshot     <= '0;
    end else begin
      mode         <= next_mode;
      selected_idx <= next_idx;
      dwell_count  <= next_dwell;
      if (load_snapshot) begin
        snapshot <= words[selected_idx];
      end
    end
  end

  // Restart the full flash indication on every index change, otherwise count down.
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      flash_count <= '0;
    end else if (next_idx != selected_idx) begin
      flash_count <= FLASH_LOAD;
    end else if (flash_count != '0) begin
      flash_count <= flash_count - FLASH_W'(1);
    end
  end

  // Register the shown word from the upcoming index so it moves together with selected_idx.
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      displayed_word <= '0;
    end else if (next_mode == VIEW_FROZEN) begin
      displayed_word <= load_snapshot ? words[selected_idx] : snapshot;
    end else begin
      displayed_word <= words[next_idx];
    end
  end

endmodule

// File: tb/tb_register_view_controller.sv
// Directed self-checking bench for register_view_controller with small
// parameters so debounce, dwell and flash timing can be walked cycle by cycle.
module tb_register_view_controller;
  import peripherals::*;

  localparam int NW = 5;

  localparam buttons_t BTN_NONE   = buttons_t'(5'b00000);
  localparam buttons_t BTN_CENTER = buttons_t'(5'b10000);
  localparam buttons_t BTN_UP     = buttons_t'(5'b01000);
  localparam buttons_t BTN_LEFT   = buttons_t'(5'b00010);
  localparam buttons_t BTN_CUP    = buttons_t'(5'b11000);

  logic               clock_100mhz;
  logic               reset;
  buttons_t           buttons;
  logic [NW-1:0][31:0] words;
  logic [2:0]         selected_idx;
  logic [31:0]        displayed_word;
  view_mode_t         mode;
  logic               flash;

  int checks;
  int failures;

  register_view_controller #(
    .NUM_WORDS      (NW),
    .DEBOUNCE_CYCLES(4),
    .DWELL_CYCLES   (10),
    .FLASH_CYCLES   (3)
  ) dut (
    .clock_100mhz  (clock_100mhz),
    .reset         (reset),
    .buttons       (buttons),
    .words         (words),
    .selected_idx  (selected_idx),
    .displayed_word(displayed_word),
    .mode          (mode),
    .flash         (flash)
  );

  initial clock_100mhz = 1'b0;
  always #5 clock_100mhz = ~clock_100mhz;

  task automatic tick(input int n);
    repeat (n) @(negedge clock_100mhz);
  endtask

  task automatic do_reset();
    buttons = BTN_NONE;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Hold a button set long enough to debounce, release it and let it settle low.
  task automatic press_and_settle(input buttons_t b);
    buttons = b;
    tick(6);
    buttons = BTN_NONE;
    tick(10);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (selected_idx !== 3'd0) begin failures++; $display("[TB] FAIL reset_idx: got %0d expected 0", selected_idx); end
    checks++; if (mode !== VIEW_MANUAL) begin failures++; $display("[TB] FAIL reset_mode: got %0d expected %0d", mode, VIEW_MANUAL); end
    checks++; if (displayed_word !== 32'h0) begin failures++; $display("[TB] FAIL reset_word: got %0h expected 0", displayed_word); end
    checks++; if (flash !== 1'b0) begin failures++; $display("[TB] FAIL reset_flash: got %0b expected 0", flash); end
  endtask

  task automatic test_manual_wrap();
    logic [2:0] exp_idx;
    logic [2:0] prev_idx;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      prev_idx = 3'(k);
      exp_idx  = (k == 4) ? 3'd0 : 3'(k + 1);
      buttons.up = 1'b1;
      tick(6);
      buttons.up = 1'b0;
      checks++; if (selected_idx !== prev_idx) begin failures++; $display("[TB] FAIL wrap_early k=%0d: got %0d expected %0d", k, selected_idx, prev_idx); end
      tick(1);
      checks++; if (selected_idx !== exp_idx) begin failures++; $display("[TB] FAIL wrap_idx k=%0d: got %0d expected %0d", k, selected_idx, exp_idx); end
      checks++; if (displayed_word !== 32'h0A0 + 32'(exp_idx)) begin failures++; $display("[TB] FAIL wrap_word k=%0d: got %0h expected %0h", k, displayed_word, 32'h0A0 + 32'(exp_idx)); end
      for (int c = 0; c < 3; c++) begin
        checks++; if (flash !== 1'b1) begin failures++; $display("[TB] FAIL wrap_flash_on k=%0d c=%0d: got %0b expected 1", k, c, flash); end
        tick(1);
      end
      checks++; if (flash !== 1'b0) begin failures++; $display("[TB] FAIL wrap_flash_off k=%0d: got %0b expected 0", k, flash); end
      tick(6);
    end
    buttons.down = 1'b1;
    tick(6);
    buttons.down = 1'b0;
    tick(1);
    checks++; if (selected_idx !== 3'd4) begin failures++; $display("[TB] FAIL down_wrap_idx: got %0d expected 4", selected_idx); end
    checks++; if (displayed_word !== 32'hA4) begin failures++; $display("[TB] FAIL down_wrap_word: got %0h expected a4", displayed_word); end
    tick(10);
  endtask

  task automatic test_debounce();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      buttons.up = (i % 2 == 0);
      tick(2);
    end
    buttons.up = 1'b0;
    tick(10);
    checks++; if (selected_idx !== 3'd0) begin failures++; $display("[TB] FAIL bounce_idx: got %0d expected 0", selected_idx); end
    buttons.up = 1'b1;
    tick(6);
    buttons.up = 1'b0;
    checks++; if (selected_idx !== 3'd0) begin failures++; $display("[TB] FAIL debounce_early: got %0d expected 0", selected_idx); end
    tick(1);
    checks++; if (selected_idx !== 3'd1) begin failures++; $display("[TB] FAIL debounce_latency: got %0d expected 1", selected_idx); end
    tick(12);
    checks++; if (selected_idx !== 3'd1) begin failures++; $display("[TB] FAIL debounce_single: got %0d expected 1", selected_idx); end
  endtask

  task automatic test_auto_scan();
    logic [2:0] exp_idx;
    do_reset();
    buttons.right = 1'b1;
    tick(6);
    buttons.right = 1'b0;
    tick(1);
    checks++; if (mode !== VIEW_AUTO) begin failures++; $display("[TB] FAIL auto_mode: got %0d expected %0d", mode, VIEW_AUTO); end
    for (int k = 1; k <= 5; k++) begin
      exp_idx = 3'(k % 5);
      tick(9);
      checks++; if (selected_idx !== 3'((k - 1) % 5)) begin failures++; $display("[TB] FAIL auto_hold k=%0d: got %0d expected %0d", k, selected_idx, (k - 1) % 5); end
      tick(1);
      checks++; if (selected_idx !== exp_idx) begin failures++; $display("[TB] FAIL auto_step k=%0d: got %0d expected %0d", k, selected_idx, exp_idx); end
    end
    tick(3);
    buttons.up = 1'b1;
    tick(6);
    buttons.up = 1'b0;
    tick(1);
    checks++; if (selected_idx !== 3'd1) begin failures++; $display("[TB] FAIL auto_collide: got %0d expected 1", selected_idx); end
    tick(9);
    checks++; if (selected_idx !== 3'd1) begin failures++; $display("[TB] FAIL auto_restart_hold: got %0d expected 1", selected_idx); end
    tick(1);
    checks++; if (selected_idx !== 3'd2) begin failures++; $display("[TB] FAIL auto_restart_step: got %0d expected 2", selected_idx); end
  endtask

  task automatic test_freeze();
    do_reset();
    press_and_settle(BTN_UP);
    press_and_settle(BTN_UP);
    press_and_settle(BTN_LEFT);
    checks++; if (mode !== VIEW_FROZEN) begin failures++; $display("[TB] FAIL freeze_mode: got %0d expected %0d", mode, VIEW_FROZEN); end
    checks++; if (displayed_word !== 32'hA2) begin failures++; $display("[TB] FAIL freeze_word: got %0h expected a2", displayed_word); end
    words[2] = 32'hDEAD;
    tick(3);
    checks++; if (displayed_word !== 32'hA2) begin failures++; $display("[TB] FAIL freeze_hold_word: got %0h expected a2", displayed_word); end
    press_and_settle(BTN_UP);
    checks++; if (selected_idx !== 3'd2) begin failures++; $display("[TB] FAIL freeze_up_idx: got %0d expected 2", selected_idx); end
    checks++; if (mode !== VIEW_FROZEN) begin failures++; $display("[TB] FAIL freeze_up_mode: got %0d expected %0d", mode, VIEW_FROZEN); end
    press_and_settle(BTN_LEFT);
    checks++; if (mode !== VIEW_MANUAL) begin failures++; $display("[TB] FAIL unfreeze_mode: got %0d expected %0d", mode, VIEW_MANUAL); end
    checks++; if (displayed_word !== 32'hDEAD) begin failures++; $display("[TB] FAIL unfreeze_word: got %0h expected dead", displayed_word); end
    words[2] = 32'hA2;
  endtask

  task automatic test_priority_center();
    do_reset();
    press_and_settle(BTN_UP);
    press_and_settle(BTN_UP);
    press_and_settle(BTN_UP);
    checks++; if (selected_idx !== 3'd3) begin failures++; $display("[TB] FAIL prio_setup: got %0d expected 3", selected_idx); end
    press_and_settle(BTN_CUP);
    checks++; if (selected_idx !== 3'd0) begin failures++; $display("[TB] FAIL prio_center_up: got %0d expected 0", selected_idx); end
    checks++; if (displayed_word !== 32'hA0) begin failures++; $display("[TB] FAIL prio_word: got %0h expected a0", displayed_word); end
    press_and_settle(BTN_UP);
    press_and_settle(BTN_UP);
    press_and_settle(BTN_LEFT);
    checks++; if (mode !== VIEW_FROZEN) begin failures++; $display("[TB] FAIL center_setup_mode: got %0d expected %0d", mode, VIEW_FROZEN); end
    press_and_settle(BTN_CENTER);
    checks++; if (mode !== VIEW_MANUAL) begin failures++; $display("[TB] FAIL center_frozen_mode: got %0d expected %0d", mode, VIEW_MANUAL); end
    checks++; if (selected_idx !== 3'd0) begin failures++; $display("[TB] FAIL center_frozen_idx: got %0d expected 0", selected_idx); end
    checks++; if (displayed_word !== 32'hA0) begin failures++; $display("[TB] FAIL center_frozen_word: got %0h expected a0", displayed_word); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    buttons.right = 1'b1;
    tick(6);
    buttons.right = 1'b0;
    tick(1);
    tick(30);
    checks++; if (selected_idx !== 3'd3) begin failures++; $display("[TB] FAIL midrst_setup_idx: got %0d expected 3", selected_idx); end
    checks++; if (flash !== 1'b1) begin failures++; $display("[TB] FAIL midrst_setup_flash: got %0b expected 1", flash); end
    reset = 1'b1;
    tick(1);
    checks++; if (selected_idx !== 3'd0) begin failures++; $display("[TB] FAIL midrst_idx: got %0d expected 0", selected_idx); end
    checks++; if (mode !== VIEW_MANUAL) begin failures++; $display("[TB] FAIL midrst_mode: got %0d expected %0d", mode, VIEW_MANUAL); end
    checks++; if (flash !== 1'b0) begin failures++; $display("[TB] FAIL midrst_flash: got %0b expected 0", flash); end
    checks++; if (displayed_word !== 32'h0) begin failures++; $display("[TB] FAIL midrst_word: got %0h expected 0", displayed_word); end
    reset = 1'b0;
    tick(12);
    checks++; if (selected_idx !== 3'd0) begin failures++; $display("[TB] FAIL midrst_after_idx: got %0d expected 0", selected_idx); end
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    buttons  = BTN_NONE;
    for (int i = 0; i < NW; i++) words[i] = 32'hA0 + 32'(i);
    tick(3);
    test_reset();
    test_manual_wrap();
    test_debounce();
    test_auto_scan();
    test_freeze();
    test_priority_center();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
